// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the MEM pipeline stage controller.
package mem_stage_pkg;

    localparam int unsigned DW         = 16;
    localparam int unsigned RD_W       = 4;
    localparam int unsigned WB_W       = 3;
    localparam int unsigned FLAG_W     = 3;
    localparam int unsigned MEM_W      = 2;
    localparam int unsigned MEM_WR_BIT = 0;
    localparam int unsigned MEM_RD_BIT = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    // Control half of an op parked while its memory access is outstanding
    typedef struct packed {
        logic [RD_W-1:0]   rd_addr;
        logic [WB_W-1:0]   wb;
        logic [FLAG_W-1:0] flags;
        logic              rd_en;
    } pend_t;

endpackage

// File: rtl/mem_stage_ctl_if.sv
// Data-memory request/ready bus between the MEM stage (master) and data memory (slave).
interface mem_stage_ctl_if #(
    parameter int unsigned DW = mem_stage_pkg::DW
) ();

    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ready;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ready
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ready
    );

endinterface

// File: rtl/mem_stage_ctl_memwb_reg.sv
// MEM/WB pipeline register: loads a full op, or a bubble that clears only the WB control.
module memwb_reg #(
    parameter int unsigned DW = mem_stage_pkg::DW
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_load,
    input  logic                              i_bubble,
    input  logic [DW-1:0]                     i_pc,
    input  logic [DW-1:0]                     i_result,
    input  logic [DW-1:0]                     i_rdata,
    input  logic [mem_stage_pkg::RD_W-1:0]    i_rd_addr,
    input  logic [mem_stage_pkg::WB_W-1:0]    i_wb,
    input  logic [mem_stage_pkg::FLAG_W-1:0]  i_flags,
    output logic [DW-1:0]                     o_pc,
    output logic [DW-1:0]                     o_result,
    output logic [DW-1:0]                     o_rdata,
    output logic [mem_stage_pkg::RD_W-1:0]    o_rd_addr,
    output logic [mem_stage_pkg::WB_W-1:0]    o_wb,
    output logic [mem_stage_pkg::FLAG_W-1:0]  o_flags
);

    // A bubble zeroes WB control so write-back does nothing; data fields keep their last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_pc      <= '0;
            o_result  <= '0;
            o_rdata   <= '0;
            o_rd_addr <= '0;
            o_wb      <= '0;
            o_flags   <= '0;
        end else if (i_load) begin
            if (i_bubble) begin
                o_wb <= '0;
            end else begin
                o_pc      <= i_pc;
                o_result  <= i_result;
                o_rdata   <= i_rdata;
                o_rd_addr <= i_rd_addr;
                o_wb      <= i_wb;
                o_flags   <= i_flags;
            end
        end
    end

endmodule

// File: rtl/mem_stage_ctl.sv
// MEM stage controller: runs the data-memory handshake for EX/MEM ops and feeds MEM/WB.
// Optional BUSY timeout with bus_err pulse is built when MEM_TIMEOUT_EN is defined.
module mem_stage_ctl #(
    parameter int unsigned DW = mem_stage_pkg::DW
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DW-1:0]                     pc_in,
    input  logic [DW-1:0]                     alu_in,
    input  logic [DW-1:0]                     data_in,
    input  logic [mem_stage_pkg::RD_W-1:0]    rd_addr_in,
    input  logic [mem_stage_pkg::MEM_W-1:0]   mem_signals_in,
    input  logic [mem_stage_pkg::WB_W-1:0]    wb_signals_in,
    input  logic [mem_stage_pkg::FLAG_W-1:0]  flags_in,
    mem_stage_ctl_if.master                   dmem,
    output logic                              stall,
    output logic [DW-1:0]                     pc_out,
    output logic [DW-1:0]                     result_out,
    output logic [DW-1:0]                     rdata_out,
    output logic [mem_stage_pkg::RD_W-1:0]    rd_addr_out,
    output logic [mem_stage_pkg::WB_W-1:0]    wb_signals_out,
    output logic [mem_stage_pkg::FLAG_W-1:0]  flags_out,
    output logic                              bus_err
);
    import mem_stage_pkg::*;

    mem_state_e       r_state;
    pend_t            r_pend;
    logic [DW-1:0]    r_pend_pc;

    logic             w_access;
    logic             w_is_wr;
    logic             w_is_rd;
    logic             w_busy;
    logic             w_done;
    logic             w_abort;

    logic             w_wb_load;
    logic             w_wb_bubble;
    logic [DW-1:0]    w_wb_pc;
    logic [DW-1:0]    w_wb_result;
    logic [DW-1:0]    w_wb_rdata;
    logic [RD_W-1:0]  w_wb_rd;
    logic [WB_W-1:0]  w_wb_ctl;
    logic [FLAG_W-1:0] w_wb_flags;

    // 2'b11 counts as a write, so a load only when the write bit is clear
    assign w_access = |mem_signals_in;
    assign w_is_wr  = mem_signals_in[MEM_WR_BIT];
    assign w_is_rd  = mem_signals_in[MEM_RD_BIT] & ~w_is_wr;
    assign w_busy   = (r_state == ST_BUSY);
    assign w_done   = w_busy & dmem.dmem_ready;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_to_cnt;

    // Ready in the final allowed cycle still completes normally
    assign w_abort = w_busy & ~dmem.dmem_ready & (r_to_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            bus_err  <= w_abort;
            r_to_cnt <= w_busy ? r_to_cnt + CNT_W'(1) : '0;
        end
    end
`else
    assign w_abort = 1'b0;
    assign bus_err = 1'b0;
`endif

    // Held low during reset so upstream never sees a stall with the pipeline cleared
    assign stall = rst & ((~w_busy & w_access) |
                          (w_busy & ~dmem.dmem_ready & ~w_abort));

    // Request FSM with latched address/data and the parked op
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            r_pend          <= '0;
            r_pend_pc       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_we    <= w_is_wr;
                        dmem.dmem_addr  <= alu_in;
                        dmem.dmem_wdata <= data_in;
                        r_pend.rd_addr  <= rd_addr_in;
                        r_pend.wb       <= wb_signals_in;
                        r_pend.flags    <= flags_in;
                        r_pend.rd_en    <= w_is_rd;
                        r_pend_pc       <= pc_in;
                        r_state         <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_done || w_abort) begin
                        dmem.dmem_req <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // MEM/WB source select: live op in IDLE, parked op on completion, bubble otherwise
    always_comb begin
        w_wb_load   = 1'b0;
        w_wb_bubble = 1'b0;
        w_wb_pc     = pc_in;
        w_wb_result = alu_in;
        w_wb_rdata  = '0;
        w_wb_rd     = rd_addr_in;
        w_wb_ctl    = wb_signals_in;
        w_wb_flags  = flags_in;
        if (!w_busy) begin
            w_wb_load   = 1'b1;
            w_wb_bubble = w_access;
        end else if (w_done) begin
            w_wb_load   = 1'b1;
            w_wb_pc     = r_pend_pc;
            w_wb_result = dmem.dmem_addr;
            w_wb_rdata  = r_pend.rd_en ? dmem.dmem_rdata : '0;
            w_wb_rd     = r_pend.rd_addr;
            w_wb_ctl    = r_pend.wb;
            w_wb_flags  = r_pend.flags;
        end else if (w_abort) begin
            w_wb_load   = 1'b1;
            w_wb_bubble = 1'b1;
        end
    end

    memwb_reg #(
        .DW (DW)
    ) u_memwb (
        .clk       (clk),
        .rst_n     (rst),
        .i_load    (w_wb_load),
        .i_bubble  (w_wb_bubble),
        .i_pc      (w_wb_pc),
        .i_result  (w_wb_result),
        .i_rdata   (w_wb_rdata),
        .i_rd_addr (w_wb_rd),
        .i_wb      (w_wb_ctl),
        .i_flags   (w_wb_flags),
        .o_pc      (pc_out),
        .o_result  (result_out),
        .o_rdata   (rdata_out),
        .o_rd_addr (rd_addr_out),
        .o_wb      (wb_signals_out),
        .o_flags   (flags_out)
    );

endmodule
